// File: rtl/axis_stall_detector_if.sv
// Per-channel AXI-stream handshake bundle observed by axis_stall_detector.
// The detector only watches tvalid/tready; it never drives the stream.
interface axis_stall_detector_if #(
  parameter int NUM_CH = 14
);
  // Valid/ready semantics: a beat transfers on a cycle where tvalid & tready;
  // tvalid without tready is a producer stall, tready without tvalid is a starved consumer.
  logic [NUM_CH-1:0] tvalid;
  logic [NUM_CH-1:0] tready;

  modport master (output tvalid, output tready);
  modport slave  (input  tvalid, input  tready);
endinterface

// File: rtl/axis_stall_detector.sv
// Per-channel AXI-stream stall counters producing registered block flags.
// Define AXIS_STALL_STICKY_EN to build the sticky block history / first-blocker capture.
module axis_stall_detector #(
  parameter int                NUM_CH   = 14,
  parameter int                CNT_W    = 16,
  parameter logic [NUM_CH-1:0] DIR_MASK = 14'h3FF0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [CNT_W-1:0]           stall_thresh,
  axis_stall_detector_if.slave       axis,
  output logic [NUM_CH-1:0]          axis_block_sigs,
  output logic                       any_block,
  input  logic                       sticky_clr,
  output logic [NUM_CH-1:0]          sticky_block,
  output logic [$clog2(NUM_CH)-1:0]  first_ch,
  output logic                       first_vld
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] blk_nxt;

  // Output streams block on a stalled producer, input streams on a starved consumer.
  always_comb begin
    stall   = '0;
    blk_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stall[i]   = DIR_MASK[i] ? (axis.tvalid[i] & ~axis.tready[i])
                               : (axis.tready[i] & ~axis.tvalid[i]);
      blk_nxt[i] = enable & stall[i] & (cnt_q[i] >= stall_thresh);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      axis_block_sigs <= '0;
      any_block       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable || !stall[i])
          cnt_q[i] <= '0;
        else if (cnt_q[i] != {CNT_W{1'b1}})
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      axis_block_sigs <= blk_nxt;
      any_block       <= |blk_nxt;
    end
  end

`ifdef AXIS_STALL_STICKY_EN
  logic [NUM_CH-1:0] rise;
  logic [IDX_W-1:0]  rise_idx;

  // Rising edge is seen one cycle early, so sticky bits update on the same edge as the block flag.
  always_comb begin
    rise     = blk_nxt & ~axis_block_sigs;
    rise_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_block <= '0;
      first_ch     <= '0;
      first_vld    <= 1'b0;
    end else if (sticky_clr) begin
      sticky_block <= '0;
      first_ch     <= '0;
      first_vld    <= 1'b0;
    end else begin
      sticky_block <= sticky_block | rise;
      if (!first_vld && (|rise)) begin
        first_ch  <= rise_idx;
        first_vld <= 1'b1;
      end
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_block      = '0;
  assign first_ch          = '0;
  assign first_vld         = 1'b0;
`endif

endmodule

// File: tb/tb_axis_stall_detector.sv
// Directed testbench for axis_stall_detector (default 14 channels, 16-bit counters).
// Sticky checks follow whichever AXIS_STALL_STICKY_EN setting the bench is compiled with.
module tb_axis_stall_detector;
  localparam int NUM_CH = 14;
  localparam int CNT_W  = 16;
  localparam logic [NUM_CH-1:0] DIR = 14'h3FF0;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [CNT_W-1:0]  thresh;
  logic              sticky_clr;
  logic [NUM_CH-1:0] blk;
  logic              any_blk;
  logic [NUM_CH-1:0] sticky;
  logic [3:0]        first_ch;
  logic              first_vld;

  int n_tests = 0;
  int n_fail  = 0;

  axis_stall_detector_if #(.NUM_CH(NUM_CH)) axis ();

  axis_stall_detector dut (
    .clock           (clk),
    .reset_n         (rst_n),
    .enable          (enable),
    .stall_thresh    (thresh),
    .axis            (axis.slave),
    .axis_block_sigs (blk),
    .any_block       (any_blk),
    .sticky_clr      (sticky_clr),
    .sticky_block    (sticky),
    .first_ch        (first_ch),
    .first_vld       (first_vld)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    axis.tvalid = '0;
    axis.tready = '0;
    tick(2);
  endtask

  task automatic test_reset();
    n_tests++;
    if (blk !== 14'h0 || any_blk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_block: got blk=%h any=%b expected 0 0", blk, any_blk);
    end
    n_tests++;
    if (sticky !== 14'h0 || first_ch !== 4'd0 || first_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sticky: got sticky=%h first_ch=%0d vld=%b expected 0 0 0", sticky, first_ch, first_vld);
    end
  endtask

  task automatic test_output_stall();
    thresh = 16'd3;
    axis.tvalid[5] = 1'b1;
    axis.tready[5] = 1'b0;
    tick(3);
    n_tests++;
    if (blk !== 14'h0) begin
      n_fail++;
      $display("FAIL out_stall_3edges: got %h expected 0000", blk);
    end
    tick(1);
    n_tests++;
    if (blk !== 14'h0020 || any_blk !== 1'b1) begin
      n_fail++;
      $display("FAIL out_stall_4edges: got blk=%h any=%b expected 0020 1", blk, any_blk);
    end
    tick(6);
    n_tests++;
    if (blk !== 14'h0020) begin
      n_fail++;
      $display("FAIL out_stall_hold: got %h expected 0020", blk);
    end
    axis.tready[5] = 1'b1;
    tick(1);
    n_tests++;
    if (blk !== 14'h0 || any_blk !== 1'b0) begin
      n_fail++;
      $display("FAIL out_stall_release: got blk=%h any=%b expected 0 0", blk, any_blk);
    end
    go_idle();
  endtask

  task automatic test_input_pulse();
    thresh = 16'd0;
    axis.tready[0] = 1'b1;
    axis.tvalid[0] = 1'b0;
    tick(1);
    n_tests++;
    if (blk !== 14'h0001 || any_blk !== 1'b1) begin
      n_fail++;
      $display("FAIL in_pulse_high: got blk=%h any=%b expected 0001 1", blk, any_blk);
    end
    axis.tvalid[0] = 1'b1;
    tick(1);
    n_tests++;
    if (blk !== 14'h0 || any_blk !== 1'b0) begin
      n_fail++;
      $display("FAIL in_pulse_low: got blk=%h any=%b expected 0 0", blk, any_blk);
    end
    go_idle();
  endtask

  task automatic test_handshake_clear();
    int bad;
    bad = 0;
    thresh = 16'd2;
    axis.tvalid[7] = 1'b1;
    axis.tready[7] = 1'b0;
    tick(1); if (blk !== 14'h0) bad++;
    tick(1); if (blk !== 14'h0) bad++;
    axis.tready[7] = 1'b1;
    tick(1); if (blk !== 14'h0) bad++;
    axis.tready[7] = 1'b0;
    tick(1); if (blk !== 14'h0) bad++;
    tick(1); if (blk !== 14'h0) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL handshake_clear: got %0d cycles with block expected 0", bad);
    end
    go_idle();
  endtask

  task automatic test_thresh_change();
    thresh = 16'd5;
    axis.tvalid[10] = 1'b1;
    axis.tready[10] = 1'b0;
    tick(3);
    n_tests++;
    if (blk !== 14'h0) begin
      n_fail++;
      $display("FAIL thresh_before: got %h expected 0000", blk);
    end
    thresh = 16'd2;
    tick(1);
    n_tests++;
    if (blk !== 14'h0400) begin
      n_fail++;
      $display("FAIL thresh_lowered: got %h expected 0400", blk);
    end
    go_idle();
  endtask

  task automatic test_independent();
    thresh = 16'd0;
    axis.tvalid[4] = 1'b1; axis.tready[4] = 1'b0;
    axis.tvalid[5] = 1'b1; axis.tready[5] = 1'b1;
    axis.tvalid[1] = 1'b1; axis.tready[1] = 1'b0;
    tick(2);
    n_tests++;
    if (blk !== 14'h0010) begin
      n_fail++;
      $display("FAIL independent: got %h expected 0010", blk);
    end
    go_idle();
  endtask

  task automatic test_enable();
    thresh = 16'd1;
    axis.tvalid = DIR;
    axis.tready = ~DIR;
    tick(2);
    n_tests++;
    if (blk !== 14'h3FFF) begin
      n_fail++;
      $display("FAIL enable_on: got %h expected 3fff", blk);
    end
    enable = 1'b0;
    tick(1);
    n_tests++;
    if (blk !== 14'h0 || any_blk !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_off: got blk=%h any=%b expected 0 0", blk, any_blk);
    end
    enable = 1'b1;
    tick(1);
    n_tests++;
    if (blk !== 14'h0) begin
      n_fail++;
      $display("FAIL enable_restart1: got %h expected 0000", blk);
    end
    tick(1);
    n_tests++;
    if (blk !== 14'h3FFF) begin
      n_fail++;
      $display("FAIL enable_restart2: got %h expected 3fff", blk);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_stall();
    thresh = 16'd1;
    axis.tvalid = DIR;
    axis.tready = ~DIR;
    tick(4);
    n_tests++;
    if (blk !== 14'h3FFF || any_blk !== 1'b1) begin
      n_fail++;
      $display("FAIL all_stalled: got blk=%h any=%b expected 3fff 1", blk, any_blk);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (blk !== 14'h0 || any_blk !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got blk=%h any=%b expected 0 0", blk, any_blk);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    n_tests++;
    if (blk !== 14'h0) begin
      n_fail++;
      $display("FAIL post_reset_edge1: got %h expected 0000", blk);
    end
    tick(1);
    n_tests++;
    if (blk !== 14'h3FFF) begin
      n_fail++;
      $display("FAIL post_reset_edge2: got %h expected 3fff", blk);
    end
    go_idle();
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    thresh = 16'hFFFF;
    axis.tvalid[9] = 1'b1;
    axis.tready[9] = 1'b0;
    for (int c = 1; c <= 70000; c++) begin
      tick(1);
      if (c == 65535) begin
        n_tests++;
        if (blk !== 14'h0) begin
          n_fail++;
          $display("FAIL sat_before: got %h expected 0000", blk);
        end
      end else if (c >= 65536 && blk !== 14'h0200) begin
        bad++;
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d cycles not 0200 expected 0", bad);
    end
    go_idle();
  endtask

  task automatic test_sticky();
    thresh = 16'd0;
    axis.tready[3] = 1'b1;
    axis.tvalid[3] = 1'b0;
    tick(1);
    axis.tvalid[8] = 1'b1;
    axis.tready[8] = 1'b0;
    tick(1);
    axis.tvalid[3] = 1'b1;
    tick(1);
    n_tests++;
    if (blk !== 14'h0100) begin
      n_fail++;
      $display("FAIL sticky_blk: got %h expected 0100", blk);
    end
`ifdef AXIS_STALL_STICKY_EN
    n_tests++;
    if (sticky !== 14'h0108 || first_ch !== 4'd3 || first_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_hist: got sticky=%h first=%0d vld=%b expected 0108 3 1", sticky, first_ch, first_vld);
    end
    sticky_clr = 1'b1;
    tick(1);
    sticky_clr = 1'b0;
    n_tests++;
    if (sticky !== 14'h0 || first_ch !== 4'd0 || first_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clr: got sticky=%h first=%0d vld=%b expected 0 0 0", sticky, first_ch, first_vld);
    end
`else
    n_tests++;
    if (sticky !== 14'h0 || first_ch !== 4'd0 || first_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_off: got sticky=%h first=%0d vld=%b expected 0 0 0", sticky, first_ch, first_vld);
    end
`endif
    go_idle();
  endtask

  initial begin
    rst_n       = 1'b1;
    enable      = 1'b1;
    thresh      = '0;
    sticky_clr  = 1'b0;
    axis.tvalid = '0;
    axis.tready = '0;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    test_output_stall();
    test_input_pulse();
    test_handshake_clear();
    test_thresh_change();
    test_independent();
    test_enable();
    test_reset_mid_stall();
    test_sticky();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_stall_detector.md
AXIS_STALL_DETECTOR -- requirements
Module: axis_stall_detector

Interface
REQ-001 SHALL have parameter NUM_CH, default 14, number of AXI-stream channels monitored.
REQ-002 SHALL have parameter CNT_W, default 16, stall counter / threshold width.
REQ-003 SHALL have parameter DIR_MASK, default 14'h3FF0, per channel: 1 = output stream (block when producer stalled), 0 = input stream (block when consumer starved).
REQ-004 SHALL have port clock  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable  input  1  1 = monitoring active; 0 = counters held at 0, outputs low.
REQ-007 SHALL have port stall_thresh  input  CNT_W  consecutive stalled cycles required before block asserts.
REQ-008 SHALL have port tvalid  input  NUM_CH  per-channel TVALID.
REQ-009 SHALL have port tready  input  NUM_CH  per-channel TREADY.
REQ-010 SHALL have port axis_block_sigs  output  NUM_CH  registered per-channel block flags, feeding the deadlock monitors.
REQ-011 SHALL have port any_block  output  1  registered OR of axis_block_sigs.
REQ-012 SHALL have port sticky_clr  input  1  clears sticky status (Configuration).
REQ-013 SHALL have port sticky_block  output  NUM_CH  sticky per-channel block history (Configuration).
REQ-014 SHALL have port first_ch  output  $clog2(NUM_CH)  index of first channel to block since clear (Configuration).
REQ-015 SHALL have port first_vld  output  1  first_ch valid (Configuration).

Function
REQ-016 Stall condition per channel i SHALL be: DIR_MASK[i]=1 -> tvalid&~tready; DIR_MASK[i]=0 -> tready&~tvalid.
REQ-017 Each channel SHALL keep a CNT_W-bit counter: +1 per cycle while stall condition holds, saturating at all-ones, no wrap.
REQ-018 Counter SHALL reset to 0 in the same cycle the condition is false (any handshake tvalid&tready, or both low).
REQ-019 axis_block_sigs[i] SHALL be registered: next value = enable & condition & (counter >= stall_thresh), counter being the pre-increment value.
REQ-020 stall_thresh=0 SHALL assert block in the cycle after the first stalled cycle; thresh=N SHALL assert it after N+1 consecutive stalled cycles.
REQ-021 Block SHALL deassert on the clock edge after the condition clears; no hysteresis.
REQ-022 any_block SHALL equal the OR of the next-state axis_block_sigs, registered in the same edge as axis_block_sigs.
REQ-023 stall_thresh SHALL be sampled every cycle; a change takes effect on the next comparison without clearing counters.
REQ-024 enable=0 SHALL force all counters to 0 and all axis_block_sigs/any_block to 0 at the next edge.
REQ-025 Channels SHALL be fully independent; simultaneous stalls on all channels SHALL be handled without interaction.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all counters, axis_block_sigs, any_block, sticky_block, first_ch, first_vld to 0.
REQ-027 Reset asserted mid-stall SHALL discard the accumulated count; counting restarts from 0 after deassertion.

Configuration
REQ-028 Macro AXIS_STALL_STICKY_EN SHALL compile in sticky status logic.
REQ-029 With macro defined: sticky_block[i] SHALL set when axis_block_sigs[i] rises and hold until sticky_clr=1 or reset; on the first rising block after clear, first_ch SHALL capture the lowest-index newly blocking channel and first_vld SHALL go 1; sticky_clr SHALL take priority over a same-cycle set.
REQ-030 Without macro: sticky_block, first_ch, first_vld SHALL be driven constant 0 and sticky_clr ignored; core function unchanged.

Verification
REQ-031 thresh=3, ch 5 (output) tvalid=1 tready=0 held for 10 cycles -> axis_block_sigs[5] rises after 4th stalled edge, stays 1, falls one edge after tready=1.
REQ-032 thresh=0, ch 0 (input) tready=1 tvalid=0 one cycle then tvalid=1 -> axis_block_sigs[0] pulses high exactly one cycle.
REQ-033 thresh=2, ch 7 stall 2 cycles, 1 handshake cycle, stall 2 cycles -> no block asserted (counter cleared by handshake).
REQ-034 thresh=1, all 14 channels stalled, reset_n pulsed low at cycle 5 -> all outputs 0 immediately; block reasserts 2 edges after release.
REQ-035 thresh=0xFFFF, ch 9 stalled 70000 cycles -> counter saturates, block asserted from cycle 65537 on, no wrap/deassert.
REQ-036 AXIS_STALL_STICKY_EN set, ch 3 then ch 8 block, ch 3 clears -> sticky_block=0x108, first_ch=3, first_vld=1; sticky_clr -> all 0.
